// File: rtl/clock_timer_core_pkg.sv
// rtl/clock_timer_core_pkg.sv - shared mode encoding, field moduli and BCD helpers
package clock_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    RESERVED  = 2'd3
  } mode_e;

  localparam int unsigned SEC_MOD = 60;
  localparam int unsigned MIN_MOD = 60;

  localparam int K_MDEC = 0;
  localparam int K_MINC = 1;
  localparam int K_HDEC = 2;
  localparam int K_HINC = 3;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/clock_timer_core_mod_counter.sv
// rtl/clock_timer_core_mod_counter.sv - up/down modulo counter with clear and wrap carry
module mod_counter #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned INIT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT);

  logic [WIDTH-1:0] value_q, value_d;

  // Next value: clear dominates, opposing inc/dec cancel, both directions wrap.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && !dec) begin
      value_d = (value_q == MAXV) ? '0 : value_q + WIDTH'(1);
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? MAXV : value_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= INITV;
    else       value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && !dec && !clr && (value_q == MAXV);

endmodule

// File: rtl/clock_timer_core.sv
// rtl/clock_timer_core.sv - parametrised time-of-day core with alarm, key edges and display feed
module clock_timer_core
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned BLINK_HALF    = TICKS_PER_SEC / 2,
  parameter int unsigned HOUR_MOD      = 24,
  parameter int unsigned INIT_HOURS    = 23,
  parameter int unsigned INIT_MINUTES  = 55,
  parameter int unsigned ALARM_SECS    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [3:0]  key_n,
  input  logic        alarm_en,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [15:0] disp_bcd,
  output logic [3:0]  disp_blank,
  output logic [7:0]  sec_led,
  output logic        blink,
  output logic        sec_tick,
  output logic        alarm
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
  localparam logic [5:0]    SEC_LAST   = 6'(SEC_MOD - 1);
  localparam logic [5:0]    MIN_LAST   = 6'(MIN_MOD - 1);
  localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MOD - 1);

  mode_e md;
  logic  in_set_time, in_set_alarm;

  logic [3:0] key_sync1_q, key_sync2_q, key_hist_q, key_press;

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [AW-1:0] alm_cnt_q, alm_cnt_d;
  logic          blink_q, blink_d, tick_d, sec_tick_q, alarm_q, alarm_d;

  logic       sec_carry, min_carry, hr_carry, alm_min_carry, alm_hr_carry;
  logic       clr_sec, alarm_hit;
  logic [5:0] alm_min, min_next;
  logic [4:0] alm_hr, hr_next, new_hr, sel_h;
  logic [5:0] sel_m;
  logic       unused_carries;

  assign md           = mode_e'(mode);
  assign in_set_time  = (md == SET_TIME);
  assign in_set_alarm = (md == SET_ALARM);

  // Two-flop synchronizer plus history; a press is the first synchronized low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync1_q <= 4'hF;
      key_sync2_q <= 4'hF;
      key_hist_q  <= 4'hF;
    end else begin
      key_sync1_q <= key_n;
      key_sync2_q <= key_sync1_q;
      key_hist_q  <= key_sync2_q;
    end
  end

  assign key_press = key_hist_q & ~key_sync2_q;

  // Prescaler, blink phase and alarm next-state; a coinciding set beats any clear.
  always_comb begin
    tick_d      = !in_set_time && (presc_q == PRESC_LAST);
    presc_d     = (in_set_time || tick_d) ? '0 : presc_q + PW'(1);
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    blink_d     = blink_q ^ (blink_cnt_q == BLINK_LAST);
    alarm_d     = alarm_q;
    alm_cnt_d   = alm_cnt_q;
    if (tick_d && alarm_q) begin
      alm_cnt_d = alm_cnt_q + AW'(1);
      if (alm_cnt_q == ALARM_LAST) alarm_d = 1'b0;
    end
    if ((|key_press) || !alarm_en) alarm_d = 1'b0;
    if (alarm_hit) begin
      alarm_d   = 1'b1;
      alm_cnt_d = '0;
    end
  end

  // Timing and alarm state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sec_tick_q  <= 1'b0;
      alarm_q     <= 1'b0;
      alm_cnt_q   <= '0;
    end else begin
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sec_tick_q  <= tick_d;
      alarm_q     <= alarm_d;
      alm_cnt_q   <= alm_cnt_d;
    end
  end

  // Minute adjust clears seconds only when it actually moves the minute.
  assign clr_sec = in_set_time && (key_press[K_MDEC] ^ key_press[K_MINC]);

  mod_counter #(.MODULUS(SEC_MOD), .WIDTH(6), .INIT(0)) u_sec (
    .clk(clk), .reset(reset), .inc(tick_d), .dec(1'b0), .clr(clr_sec),
    .value(seconds), .carry(sec_carry)
  );

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(6), .INIT(INIT_MINUTES)) u_min (
    .clk(clk), .reset(reset),
    .inc(sec_carry || (in_set_time && key_press[K_MINC])),
    .dec(in_set_time && key_press[K_MDEC]), .clr(1'b0),
    .value(minutes), .carry(min_carry)
  );

  // Manual minute wraps must not ripple into hours, hence the tick qualifier.
  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(5), .INIT(INIT_HOURS)) u_hr (
    .clk(clk), .reset(reset),
    .inc((min_carry && tick_d) || (in_set_time && key_press[K_HINC])),
    .dec(in_set_time && key_press[K_HDEC]), .clr(1'b0),
    .value(hours), .carry(hr_carry)
  );

  mod_counter #(.MODULUS(MIN_MOD), .WIDTH(6), .INIT(0)) u_alm_min (
    .clk(clk), .reset(reset),
    .inc(in_set_alarm && key_press[K_MINC]),
    .dec(in_set_alarm && key_press[K_MDEC]), .clr(1'b0),
    .value(alm_min), .carry(alm_min_carry)
  );

  mod_counter #(.MODULUS(HOUR_MOD), .WIDTH(5), .INIT(0)) u_alm_hr (
    .clk(clk), .reset(reset),
    .inc(in_set_alarm && key_press[K_HINC]),
    .dec(in_set_alarm && key_press[K_HDEC]), .clr(1'b0),
    .value(alm_hr), .carry(alm_hr_carry)
  );

  assign unused_carries = hr_carry ^ alm_min_carry ^ alm_hr_carry;

  // The alarm matches the time the tick is about to produce, which is always hh:mm:00.
  assign min_next  = (minutes == MIN_LAST) ? 6'd0 : minutes + 6'd1;
  assign hr_next   = (hours == HOUR_LAST) ? 5'd0 : hours + 5'd1;
  assign new_hr    = (minutes == MIN_LAST) ? hr_next : hours;
  assign alarm_hit = alarm_en && tick_d && (seconds == SEC_LAST) &&
                     (min_next == alm_min) && (new_hr == alm_hr);

  assign sel_h      = in_set_alarm ? alm_hr  : hours;
  assign sel_m      = in_set_alarm ? alm_min : minutes;
  assign disp_bcd   = {bcd_tens({1'b0, sel_h}), bcd_ones({1'b0, sel_h}),
                       bcd_tens(sel_m), bcd_ones(sel_m)};
  assign disp_blank = (in_set_time || in_set_alarm) ? {4{blink_q}} : 4'h0;
  assign sec_led    = {2'b00, in_set_time ? (seconds & {6{~blink_q}}) : seconds};
  assign blink      = blink_q;
  assign sec_tick   = sec_tick_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_clock_timer_core.sv
// tb/tb_clock_timer_core.sv - randomized and directed check of clock_timer_core against a time-of-day model
module tb_clock_timer_core;

  localparam int T     = 10;
  localparam int BH    = 4;
  localparam int HMOD  = 24;
  localparam int ASECS = 60;
  localparam int DAY   = HMOD * 3600;
  localparam int INIT_T = (23 * 60 + 55) * 60;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [3:0]  key_n;
  logic        alarm_en;
  logic [4:0]  hours;
  logic [5:0]  minutes, seconds;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_blank;
  logic [7:0]  sec_led;
  logic        blink, sec_tick, alarm;

  int n_vec = 0;
  int n_err = 0;

  // model state: time as seconds of day, alarm as minutes of day
  int   m_t, m_alm, m_p, m_cyc, m_aticks;
  bit   m_tick, m_alarm;
  logic [3:0] s1, s2, s3;

  clock_timer_core #(
    .TICKS_PER_SEC(T), .BLINK_HALF(BH), .HOUR_MOD(HMOD),
    .INIT_HOURS(23), .INIT_MINUTES(55), .ALARM_SECS(ASECS)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .key_n(key_n), .alarm_en(alarm_en),
    .hours(hours), .minutes(minutes), .seconds(seconds), .disp_bcd(disp_bcd),
    .disp_blank(disp_blank), .sec_led(sec_led), .blink(blink),
    .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int adj(input int hm, input logic [3:0] e);
    int h, m;
    h = hm / 60;
    m = hm % 60;
    if (e[1] && !e[0]) m = (m + 1) % 60;
    else if (e[0] && !e[1]) m = (m + 59) % 60;
    if (e[3] && !e[2]) h = (h + 1) % HMOD;
    else if (e[2] && !e[3]) h = (h + HMOD - 1) % HMOD;
    return h * 60 + m;
  endfunction

  function automatic int eff_mode(input logic [1:0] md);
    return (md == 2'd1) ? 1 : (md == 2'd2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_t = INIT_T; m_alm = 0; m_p = 0; m_cyc = 0; m_aticks = 0;
    m_tick = 0; m_alarm = 0;
    s1 = 4'hF; s2 = 4'hF; s3 = 4'hF;
  endtask

  task automatic model_edge();
    logic [3:0] ev;
    int  md;
    bit  hit, na;
    ev = s3 & ~s2;
    s3 = s2; s2 = s1; s1 = key_n;
    md = eff_mode(mode);
    m_cyc++;
    m_tick = 0;
    if (md == 1) m_p = 0;
    else begin
      m_p++;
      if (m_p == T) begin m_p = 0; m_tick = 1; end
    end
    hit = 0;
    if (m_tick) begin
      m_t = (m_t + 1) % DAY;
      hit = alarm_en && (m_t % 60 == 0) && (m_t / 60 == m_alm);
    end
    if (md == 1 && ev != 0)
      m_t = adj(m_t / 60, ev) * 60 + ((ev[0] ^ ev[1]) ? 0 : m_t % 60);
    if (md == 2 && ev != 0)
      m_alm = adj(m_alm, ev);
    na = m_alarm;
    if (m_tick && m_alarm) begin
      m_aticks++;
      if (m_aticks == ASECS) na = 0;
    end
    if (ev != 0 || !alarm_en) na = 0;
    if (hit) begin na = 1; m_aticks = 0; end
    m_alarm = na;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_edge();
    #2;
  endtask

  // compare every output against the model on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      int h, m, s, sh, sm, md;
      bit b;
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      b = ((m_cyc / BH) % 2) == 1;
      md = eff_mode(mode);
      sh = (md == 2) ? m_alm / 60 : h;
      sm = (md == 2) ? m_alm % 60 : m;
      check("hours", 32'(hours), 32'(h));
      check("minutes", 32'(minutes), 32'(m));
      check("seconds", 32'(seconds), 32'(s));
      check("disp_bcd", 32'(disp_bcd),
            32'(((sh / 10) << 12) | ((sh % 10) << 8) | ((sm / 10) << 4) | (sm % 10)));
      check("disp_blank", 32'(disp_blank), (md != 0 && b) ? 32'hF : 32'h0);
      check("sec_led", 32'(sec_led), (md == 1 && b) ? 32'h0 : 32'(s));
      check("blink", 32'(blink), 32'(b));
      check("sec_tick", 32'(sec_tick), 32'(m_tick));
      check("alarm", 32'(alarm), 32'(m_alarm));
    end
  end

  task automatic press(input logic [3:0] kn, input int hold);
    key_n = kn;
    repeat (hold) cycle();
    key_n = 4'hF;
    repeat (4) cycle();
  endtask

  initial begin
    logic [3:0] prev_blank;
    int toggles;
    reset = 1'b1; mode = 2'd0; key_n = 4'hF; alarm_en = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    check("rst_hours", 32'(hours), 32'd23);
    check("rst_minutes", 32'(minutes), 32'd55);
    check("rst_seconds", 32'(seconds), 32'd0);
    check("rst_bcd", 32'(disp_bcd), 32'h2355);
    check("rst_alarm", 32'(alarm), 32'd0);

    // 300 seconds from 23:55:00 roll the whole day over
    repeat (3000) cycle();
    check("roll_tick", 32'(sec_tick), 32'd1);
    check("roll_time", {hours, minutes, seconds}, 32'd0);

    repeat (370) cycle();
    check("t2_sec37", 32'(seconds), 32'd37);
    mode = 2'd1;
    repeat (5) cycle();
    key_n = 4'b1110;
    repeat (2) cycle();
    check("t2_before3rd", 32'(minutes), 32'd0);
    cycle();
    check("t2_min59", 32'(minutes), 32'd59);
    check("t2_sec0", 32'(seconds), 32'd0);
    repeat (2) cycle();
    key_n = 4'hF;
    repeat (4) cycle();
    press(4'b1011, 4);
    check("t2_hdec", 32'(hours), 32'd23);
    press(4'b0111, 4);
    check("t2_hinc_wrap", 32'(hours), 32'd0);

    press(4'b1100, 50);
    check("t3_cancel_min", 32'(minutes), 32'd59);
    press(4'b1101, 50);
    check("t3_held_once", 32'(minutes), 32'd0);

    mode = 2'd2;
    press(4'b1101, 4);
    check("t4_alm_disp", 32'(disp_bcd), 32'h0001);
    mode = 2'd1;
    cycle();
    mode = 2'd0; alarm_en = 1'b1;
    repeat (580) cycle();
    check("t4_sec58", 32'(seconds), 32'd58);
    repeat (20) cycle();
    check("t4_alarm_on", 32'(alarm), 32'd1);
    check("t4_min1", 32'(minutes), 32'd1);
    repeat (590) cycle();
    check("t4_alarm_held", 32'(alarm), 32'd1);
    repeat (10) cycle();
    check("t4_alarm_timeout", 32'(alarm), 32'd0);
    mode = 2'd2;
    press(4'b1101, 4);
    press(4'b1101, 4);
    mode = 2'd0;
    for (int i = 0; i < 1000 && alarm !== 1'b1; i++) cycle();
    check("t4_rearm", 32'(alarm), 32'd1);
    check("t4_rearm_min", 32'(minutes), 32'd3);
    key_n = 4'b1011;
    repeat (4) cycle();
    key_n = 4'hF;
    check("t4_key_dismiss", 32'(alarm), 32'd0);
    check("t4_run_hours", 32'(hours), 32'd0);
    check("t4_run_min", 32'(minutes), 32'd3);
    repeat (4) cycle();

    mode = 2'd1;
    cycle();
    prev_blank = disp_blank;
    toggles = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (disp_blank != prev_blank) toggles++;
      prev_blank = disp_blank;
    end
    check("t5_blank_toggles", 32'(toggles), 32'd2);
    mode = 2'd0;
    cycle();
    check("t5_run_unblank", 32'(disp_blank), 32'd0);

    mode = 2'd2;
    key_n = 4'b1101;
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_hours", 32'(hours), 32'd23);
    key_n = 4'hF;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (6) cycle();
    check("t6_alm_disp", 32'(disp_bcd), 32'h0000);
    check("t6_time", {hours, minutes, seconds}, {5'd23, 6'd55, 6'd0});

    alarm_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
      for (int k = 0; k < 4; k++)
        if ($urandom_range(15) == 0) key_n[k] = ~key_n[k];
      if ($urandom_range(299) == 0) alarm_en = ~alarm_en;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
